dsp_qid_alloc: RTL

DSP_QID_ALLOC -- requirements
Module: dsp_qid_alloc

---
 rtl/dsp_qid_alloc_pkg.sv | 34 +++
 rtl/dsp_popcnt.sv | 19 +
 rtl/dsp_qid_alloc_chk.sv | 42 ++++
 rtl/gnrl_dfflr.sv | 22 ++
 rtl/dsp_qid_alloc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/dsp_qid_alloc_pkg.sv
// Shared dispatch package.
// Holds the default queue-ID pool geometry for the dispatch stage, the
// load/store buffer ID widths that sit next to it, the lane-count width used
// by the popcount helpers, and the flush classification used by the allocator.
package dsp_qid_alloc_pkg;

    // Default pool size and lane counts for the dispatch queue-ID allocator.
    localparam int DSP_DEPTH = 32;
    localparam int DSP_NREQ  = 4;
    localparam int DSP_NRET  = 4;

    // Load and store buffer ID widths used elsewhere in the dispatch slice.
    localparam int LBUFF_IDW = 4;
    localparam int SBUFF_IDW = 4;

    // Width that holds a popcount of up to 8 lanes (0..8).
    localparam int DSP_CNTW = 4;

    // ID width for a power-of-two pool of the given depth.
    function automatic int dsp_idw(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DSP_IDW = dsp_idw(DSP_DEPTH);

    // Which flush, if any, governs the pointer update this cycle.
    typedef enum logic [1:0] {
        FLUSH_NONE     = 2'd0,
        FLUSH_TRAP     = 2'd1,
        FLUSH_MIS_ROLL = 2'd2,
        FLUSH_MIS_HOLD = 2'd3
    } dsp_flush_e;

endpackage

// File: rtl/dsp_popcnt.sv
// Combinational population count.
// Ports: i_vec (W-bit input vector), o_cnt (OW-bit count of set bits).
module dsp_popcnt #(
    parameter int W  = 4,
    parameter int OW = 4
) (
    input  logic [W-1:0]  i_vec,
    output logic [OW-1:0] o_cnt
);

    // Ripple sum of the set bits.
    always_comb begin
        o_cnt = {OW{1'b0}};
        for (int i = 0; i < W; i++) begin
            o_cnt = o_cnt + OW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/dsp_qid_alloc_chk.sv
// Simulation checker for the queue-ID allocator: flags retire overrun and a
// rollback pointer that lies outside the surviving window.
// Ports: clk, rst_n, flush controls, rollback ID, pointer state, occupancy,
// retire count.
module dsp_qid_alloc_chk #(
    parameter int IDW  = 5,
    parameter int CNTW = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            trap,
    input logic            mis,
    input logic            mis_id_vld,
    input logic [IDW:0]    mis_id,
    input logic [IDW:0]    wr_ptr,
    input logic [IDW:0]    rd_ptr,
    input logic [IDW:0]    occ,
    input logic [CNTW-1:0] nret
);

    localparam int PW   = IDW + 1;
    localparam int CMPW = (PW > CNTW) ? PW : CNTW;

    logic [PW-1:0] lo_s;
    logic [PW-1:0] span_s;
    logic [PW-1:0] off_s;

    // Oldest surviving entry after this cycle's retirement, and distances
    // from it measured modulo the pointer space.
    assign lo_s   = rd_ptr + PW'(nret);
    assign span_s = wr_ptr - lo_s;
    assign off_s  = mis_id - lo_s;

    a_ret_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !trap |-> (CMPW'(nret) <= CMPW'(occ)))
        else $error("dsp_qid_alloc: retire count exceeds occupancy");

    a_mis_range: assert property (@(posedge clk) disable iff (!rst_n)
        (!trap && mis && mis_id_vld) |-> (off_s <= span_s))
        else $error("dsp_qid_alloc: rollback ID outside live window");

endmodule

// File: rtl/gnrl_dfflr.sv
// General load-enabled flop with asynchronous active-low reset to zero.
// Ports: clk, rst_n, lden (load enable), dnxt (next value), qout (state).
module gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // State register: cleared by reset, loaded when lden is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= {DW{1'b0}};
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/dsp_qid_alloc.sv
// Dispatch queue-ID allocator.
// Hands out up to NREQ consecutive IDs per cycle (all-or-nothing) from a
// circular pool of DEPTH entries and reclaims up to NRET per cycle in order.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   i_trap_flush         reset both pointers to zero
//   i_mis_flush          mispredict / load-store flush
//   i_mis_id_vld/i_mis_id  rollback allocation pointer (wrap bit included)
//   i_stall              block allocation
//   i_req_vld            per-lane request; o_req_gnt grants the whole group
//   o_req_id             per-lane ID, lane k at [k*IDW +: IDW]
//   i_ret_vld            per-lane retire
//   o_dsp_ptr/o_ret_ptr  allocation and retire pointers (registered)
//   o_free_cnt/o_full/o_empty  pool status
module dsp_qid_alloc
    import dsp_qid_alloc_pkg::*;
#(
    parameter int  DEPTH = DSP_DEPTH,
    parameter int  NREQ  = DSP_NREQ,
    parameter int  NRET  = DSP_NRET,
    localparam int IDW   = dsp_idw(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_trap_flush,
    input  logic                i_mis_flush,
    input  logic                i_mis_id_vld,
    input  logic [IDW:0]        i_mis_id,
    input  logic                i_stall,
    input  logic [NREQ-1:0]     i_req_vld,
    output logic                o_req_gnt,
    output logic [NREQ*IDW-1:0] o_req_id,
    input  logic [NRET-1:0]     i_ret_vld,
    output logic [IDW:0]        o_dsp_ptr,
    output logic [IDW:0]        o_ret_ptr,
    output logic [IDW:0]        o_free_cnt,
    output logic                o_full,
    output logic                o_empty
);

    localparam int PW   = IDW + 1;
    localparam int CMPW = (PW > DSP_CNTW) ? PW : DSP_CNTW;

    logic [PW-1:0]       wr_r;
    logic [PW-1:0]       rd_r;
    logic [PW-1:0]       wr_nxt_s;
    logic [PW-1:0]       rd_nxt_s;
    logic                wr_ld_s;
    logic                rd_ld_s;
    logic [PW-1:0]       occ_s;
    logic [PW-1:0]       free_s;
    logic [DSP_CNTW-1:0] nreq_s;
    logic [DSP_CNTW-1:0] nret_s;
    logic [DSP_CNTW-1:0] pfx_s [NREQ];
    logic [PW-1:0]       lane_ptr_s [NREQ];
    logic                gnt_s;
    dsp_flush_e          flush_s;

    dsp_popcnt #(.W(NREQ), .OW(DSP_CNTW)) u_nreq (
        .i_vec (i_req_vld),
        .o_cnt (nreq_s)
    );

    dsp_popcnt #(.W(NRET), .OW(DSP_CNTW)) u_nret (
        .i_vec (i_ret_vld),
        .o_cnt (nret_s)
    );

    // Lane k is offset by the number of valid lanes below it, so valid lanes
    // receive consecutive IDs and an invalid lane shares its upper neighbour's.
    assign pfx_s[0] = {DSP_CNTW{1'b0}};

    for (genvar k = 1; k < NREQ; k++) begin : g_pfx
        dsp_popcnt #(.W(k), .OW(DSP_CNTW)) u_pfx (
            .i_vec (i_req_vld[k-1:0]),
            .o_cnt (pfx_s[k])
        );
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign lane_ptr_s[k]          = wr_r + PW'(pfx_s[k]);
        assign o_req_id[k*IDW +: IDW] = lane_ptr_s[k][IDW-1:0];
    end

    // Occupancy is taken modulo the pointer space; the wrap bit makes a full
    // pool (occupancy DEPTH) distinct from an empty one.
    assign occ_s  = wr_r - rd_r;
    assign free_s = PW'(DEPTH) - occ_s;

    // Grant only against entries free at the start of the cycle; entries
    // retired this cycle become available next cycle.
    assign gnt_s = (nreq_s != {DSP_CNTW{1'b0}})
                && (CMPW'(nreq_s) <= CMPW'(free_s))
                && !i_stall && !i_trap_flush && !i_mis_flush;

    // Flush priority: trap over mispredict; a mispredict without a rollback
    // ID only suppresses allocation.
    always_comb begin
        if (i_trap_flush) begin
            flush_s = FLUSH_TRAP;
        end else if (i_mis_flush && i_mis_id_vld) begin
            flush_s = FLUSH_MIS_ROLL;
        end else if (i_mis_flush) begin
            flush_s = FLUSH_MIS_HOLD;
        end else begin
            flush_s = FLUSH_NONE;
        end
    end

    // Next-pointer selection; retirement continues through a mispredict.
    always_comb begin
        wr_nxt_s = wr_r;
        wr_ld_s  = 1'b0;
        rd_nxt_s = rd_r + PW'(nret_s);
        rd_ld_s  = (nret_s != {DSP_CNTW{1'b0}});
        case (flush_s)
            FLUSH_TRAP: begin
                wr_nxt_s = {PW{1'b0}};
                wr_ld_s  = 1'b1;
                rd_nxt_s = {PW{1'b0}};
                rd_ld_s  = 1'b1;
            end
            FLUSH_MIS_ROLL: begin
                wr_nxt_s = i_mis_id;
                wr_ld_s  = 1'b1;
            end
            FLUSH_MIS_HOLD: begin
                wr_ld_s = 1'b0;
            end
            FLUSH_NONE: begin
                if (gnt_s) begin
                    wr_nxt_s = wr_r + PW'(nreq_s);
                    wr_ld_s  = 1'b1;
                end else begin
                    wr_ld_s = 1'b0;
                end
            end
            default: begin
                wr_nxt_s = wr_r;
                wr_ld_s  = 1'b0;
            end
        endcase
    end

    gnrl_dfflr #(.DW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (wr_ld_s),
        .dnxt  (wr_nxt_s),
        .qout  (wr_r)
    );

    gnrl_dfflr #(.DW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (rd_ld_s),
        .dnxt  (rd_nxt_s),
        .qout  (rd_r)
    );

    assign o_req_gnt  = gnt_s;
    assign o_dsp_ptr  = wr_r;
    assign o_ret_ptr  = rd_r;
    assign o_free_cnt = free_s;
    assign o_full     = (free_s == {PW{1'b0}});
    assign o_empty    = (free_s == PW'(DEPTH));

    dsp_qid_alloc_chk #(.IDW(IDW), .CNTW(DSP_CNTW)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .trap       (i_trap_flush),
        .mis        (i_mis_flush),
        .mis_id_vld (i_mis_id_vld),
        .mis_id     (i_mis_id),
        .wr_ptr     (wr_r),
        .rd_ptr     (rd_r),
        .occ        (occ_s),
        .nret       (nret_s)
    );

endmodule
